// File: rtl/sdiomux_multi_counter.sv
// Multi-channel bidirectional pad test design: each channel synchronises its pad,
// counts active samples and tristate-drives the pad from one bit of its own counter.
module sdiomux_multi_counter #(
   parameter int CHANNELS    = 4,
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int OE_BIT      = 0,
   parameter int OPEN_DRAIN  = 0,
   parameter int SELF_COUNT  = 1,
   parameter int TURNAROUND  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   inout  wire  [CHANNELS-1:0] io,
   output logic [WIDTH-1:0]    led,
   output logic [CHANNELS-1:0] ovf
);

   localparam logic             ACT  = (OPEN_DRAIN != 0) ? 1'b0 : 1'b1;
   localparam logic [7:0]       TA   = 8'(TURNAROUND);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ALL1 = '1;

   if (OE_BIT >= WIDTH || (SELF_COUNT == 0 && TURNAROUND < SYNC_STAGES)) begin : g_bad_param
      $error("sdiomux_multi_counter: OE_BIT must be < WIDTH and TURNAROUND >= SYNC_STAGES when SELF_COUNT=0");
   end

   logic [WIDTH-1:0] cnt [CHANNELS];

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync;
      logic [7:0]             tcnt;
      logic [WIDTH-1:0]       cnt_r;
      logic                   ovf_r;
      logic                   oe;
      logic                   act;
      logic                   mask;
      logic                   inc;

      assign oe    = cnt_r[OE_BIT];
      assign act   = (sync[SYNC_STAGES-1] == ACT);
      // Own drive is echoed back through the synchroniser, so the mask must
      // outlast oe by at least the synchroniser depth.
      assign mask  = (SELF_COUNT == 0) && (oe || (tcnt != 8'd0));
      assign inc   = act && !mask;
      assign io[i] = oe ? ACT : 1'bz;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            sync  <= {SYNC_STAGES{~ACT}};
            tcnt  <= 8'd0;
            cnt_r <= '0;
            ovf_r <= 1'b0;
         end else begin
            sync[0] <= io[i];
            for (int k = 1; k < SYNC_STAGES; k++) begin
               sync[k] <= sync[k-1];
            end
            if (oe) begin
               tcnt <= TA;
            end else if (tcnt != 8'd0) begin
               tcnt <= tcnt - 8'd1;
            end
            if (inc) begin
               cnt_r <= cnt_r + ONE;
               if (cnt_r == ALL1) begin
                  ovf_r <= 1'b1;
               end
            end
         end
      end

      assign cnt[i] = cnt_r;
      assign ovf[i] = ovf_r;
   end

   for (genvar k = 0; k < WIDTH; k++) begin : g_led
      assign led[WIDTH-1-k] = cnt[0][k];
   end

endmodule
